// File: rtl/adc_channel_scan_master.sv
// adc_channel_scan_master: Avalon-MM initiator that steps an ADC channel-select PIO,
// waits for the analog front end to settle, reads one sample and streams {channel, sample}.
module adc_channel_scan_master #(
    parameter int                NUM_CH        = 2,
    parameter int                ADDR_W        = 4,
    parameter logic [ADDR_W-1:0] SEL_ADDR      = 4'h0,
    parameter logic [ADDR_W-1:0] SAMPLE_ADDR   = 4'h8,
    parameter int                DATA_W        = 32,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] smp_data,
    output logic [CH_W-1:0]   smp_ch,
    output logic              smp_valid,
    input  logic              smp_ready
);
    localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, WR_SEL, SETTLE, RD, OUT} state_t;

    state_t           state;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ch            <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            avm_address   <= '0;
            avm_write     <= 1'b0;
            avm_read      <= 1'b0;
            avm_writedata <= '0;
            smp_data      <= '0;
            smp_ch        <= '0;
            smp_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= WR_SEL;
                        ch            <= '0;
                        busy          <= 1'b1;
                        avm_write     <= 1'b1;
                        avm_address   <= SEL_ADDR;
                        avm_writedata <= '0;
                    end
                end
                WR_SEL: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            state       <= RD;
                            avm_read    <= 1'b1;
                            avm_address <= SAMPLE_ADDR;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LOAD;
                        end
                    end
                end
                // counter is loaded with N-1 so that exactly N cycles are spent here
                SETTLE: begin
                    if (cnt == '0) begin
                        state       <= RD;
                        avm_read    <= 1'b1;
                        avm_address <= SAMPLE_ADDR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD: begin
                    if (!avm_waitrequest) begin
                        state     <= OUT;
                        avm_read  <= 1'b0;
                        smp_data  <= avm_readdata;
                        smp_ch    <= ch;
                        smp_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (smp_ready) begin
                        smp_valid <= 1'b0;
                        if (ch != LAST_CH) begin
                            state         <= WR_SEL;
                            ch            <= ch + 1'b1;
                            avm_write     <= 1'b1;
                            avm_address   <= SEL_ADDR;
                            avm_writedata <= DATA_W'(CH_W'(ch + 1'b1));
                        end else if (continuous) begin
                            state         <= WR_SEL;
                            ch            <= '0;
                            avm_write     <= 1'b1;
                            avm_address   <= SEL_ADDR;
                            avm_writedata <= '0;
                        end else begin
                            state <= IDLE;
                            ch    <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_channel_scan_master.sv
// Randomized scoreboard bench for adc_channel_scan_master: a bus-level reference model predicts
// channel order, sample data, settle timing and busy; a monitor pops and compares each sample.
module tb_adc_channel_scan_master;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int SETTLE = 4;

    logic              clk = 1'b0, reset = 1'b0, start = 1'b0, continuous = 1'b0;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_waitrequest = 1'b0, smp_ready = 1'b0;

    logic              busy, avm_write, avm_read, smp_valid;
    logic [3:0]        avm_address;
    logic [DATA_W-1:0] avm_writedata, smp_data;
    logic [0:0]        smp_ch;

    logic              busy_z, avm_write_z, avm_read_z, smp_valid_z;
    logic [3:0]        avm_address_z;
    logic [DATA_W-1:0] avm_writedata_z, smp_data_z;
    logic [0:0]        smp_ch_z;

    adc_channel_scan_master #(.NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE)) u_dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .busy(busy),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .smp_data(smp_data), .smp_ch(smp_ch),
        .smp_valid(smp_valid), .smp_ready(smp_ready));

    // single-channel, zero-settle variant sharing the same stimulus
    adc_channel_scan_master #(.NUM_CH(1), .SETTLE_CYCLES(0)) u_dut_z (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous), .busy(busy_z),
        .avm_address(avm_address_z), .avm_write(avm_write_z), .avm_read(avm_read_z),
        .avm_writedata(avm_writedata_z), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .smp_data(smp_data_z), .smp_ch(smp_ch_z),
        .smp_valid(smp_valid_z), .smp_ready(smp_ready));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // slave behaviour: random stalls, random sample data, random downstream readiness
    int unsigned wr_pct = 0, rdy_pct = 100;
    bit          wr_force = 0, data_fixed = 0;
    logic [31:0] fixed_data = '0;

    always @(posedge clk) begin
        #1;
        avm_waitrequest = wr_force ? 1'b1 : ($urandom_range(0, 99) < wr_pct);
        smp_ready       = ($urandom_range(0, 99) < rdy_pct);
        avm_readdata    = data_fixed ? fixed_data : $urandom();
    end

    // reference model + scoreboard, evaluated on the falling edge for the coming rising edge
    int          exp_ch_q[$];
    logic [31:0] exp_d_q[$];
    int          m_ch = 0, gap = 0, hs_count = 0;
    bit          m_busy = 0, in_settle = 0, exp_wr = 0, exp_vld = 0;
    bit          p_wr_stall = 0, p_rd_stall = 0, p_vld_stall = 0, pz_wacc = 0;
    logic [3:0]  p_addr;
    logic [31:0] p_wdata, p_sdata;
    logic [0:0]  p_sch;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 0; m_ch = 0; in_settle = 0; exp_wr = 0; exp_vld = 0;
            p_wr_stall = 0; p_rd_stall = 0; p_vld_stall = 0; pz_wacc = 0;
            exp_ch_q.delete(); exp_d_q.delete();
        end else begin
            chk("busy", busy, m_busy);
            if (avm_read && avm_write) chk("rd_wr_exclusive", 1, 0);
            if (smp_valid && (avm_read || avm_write)) chk("bus_quiet_while_valid", 1, 0);
            if (exp_wr) begin chk("write_issue", avm_write, 1); exp_wr = 0; end
            if (exp_vld) begin chk("valid_after_read", smp_valid, 1); exp_vld = 0; end
            if (p_wr_stall)
                chk("wr_hold", {avm_write, avm_address, avm_writedata}, {1'b1, p_addr, p_wdata});
            if (p_rd_stall) chk("rd_hold", {avm_read, avm_address}, {1'b1, p_addr});
            if (p_vld_stall)
                chk("vld_hold", {smp_valid, smp_ch, smp_data}, {1'b1, p_sch, p_sdata});
            if (in_settle) begin
                gap++;
                if (avm_read || gap == SETTLE + 1) begin
                    chk("settle_gap", gap, SETTLE + 1);
                    in_settle = 0;
                end
            end

            if (start && !m_busy) begin m_busy = 1; m_ch = 0; exp_wr = 1; end
            if (avm_write && !avm_waitrequest) begin
                chk("sel_addr", avm_address, 4'h0);
                chk("sel_ch", avm_writedata, m_ch);
                in_settle = 1; gap = 0;
            end
            if (avm_read && !avm_waitrequest) begin
                chk("smp_addr", avm_address, 4'h8);
                exp_ch_q.push_back(m_ch);
                exp_d_q.push_back(avm_readdata);
                exp_vld = 1;
            end
            if (smp_valid && smp_ready) begin
                hs_count++;
                if (exp_ch_q.size() == 0) chk("unexpected_sample", 1, 0);
                else begin
                    chk("smp_ch", smp_ch, exp_ch_q.pop_front());
                    chk("smp_data", smp_data, exp_d_q.pop_front());
                end
                if (m_ch < NUM_CH - 1) begin m_ch++; exp_wr = 1; end
                else if (continuous) begin m_ch = 0; exp_wr = 1; end
                else begin m_ch = 0; m_busy = 0; end
            end

            if (pz_wacc) chk("z_read_after_write", avm_read_z, 1);
            if (avm_write_z && !avm_waitrequest) chk("z_wdata", avm_writedata_z, 0);
            if (smp_valid_z && smp_ready) chk("z_ch", smp_ch_z, 0);

            p_wr_stall  = avm_write && avm_waitrequest;
            p_rd_stall  = avm_read && avm_waitrequest;
            p_vld_stall = smp_valid && !smp_ready;
            p_addr      = avm_address;
            p_wdata     = avm_writedata;
            p_sdata     = smp_data;
            p_sch       = smp_ch;
            pz_wacc     = avm_write_z && !avm_waitrequest;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin @(posedge clk); #1; n++; end
        chk("idle_reached", busy, 0);
    endtask

    initial begin
        int base, n;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_write", avm_write, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_valid", smp_valid, 0);
        chk("rst_data", smp_data, 0);
        chk("rst_ch", smp_ch, 0);
        reset = 1'b0;

        // clean sweep, no stalls
        wr_pct = 0; rdy_pct = 100;
        @(posedge clk); #1;
        base = hs_count;
        pulse_start();
        wait_idle(200);
        chk("sweep_samples", hs_count - base, 2);

        // downstream back-pressure with fixed data
        data_fixed = 1; fixed_data = 32'hDEAD_BEEF; rdy_pct = 0;
        pulse_start();
        n = 0;
        while (!smp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_valid_seen", smp_valid, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("bp_valid_held", smp_valid, 1);
        chk("bp_data", smp_data, 32'hDEAD_BEEF);
        rdy_pct = 100;
        wait_idle(200);
        data_fixed = 0;

        // random stalls and readiness
        for (int s = 0; s < 6; s++) begin
            wr_pct  = $urandom_range(10, 60);
            rdy_pct = $urandom_range(30, 100);
            pulse_start();
            wait_idle(3000);
        end

        // continuous sweeps, cleared during the fourth sweep, with stray start pulses
        wr_pct = 20; rdy_pct = 80;
        base = hs_count;
        continuous = 1'b1;
        pulse_start();
        n = 0;
        while (hs_count - base < 7 && n < 5000) begin
            start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        continuous = 1'b0;
        wait_idle(3000);
        chk("cont_samples", hs_count - base, 8);

        // async reset while a read is stalled
        wr_pct = 0; rdy_pct = 100;
        pulse_start();
        n = 0;
        while (!avm_read && n < 100) begin @(posedge clk); #1; n++; end
        wr_force = 1; avm_waitrequest = 1'b1;
        @(posedge clk); #2;
        chk("rst_mid_read_before", avm_read, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_read", avm_read, 0);
        chk("rst_mid_write", avm_write, 0);
        chk("rst_mid_valid", smp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b0; wr_force = 0;
        @(posedge clk); #1;
        base = hs_count;
        pulse_start();
        wait_idle(200);
        chk("restart_samples", hs_count - base, 2);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_ch_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
